// File: rtl/fc_layer_engine.sv
// Fully connected layer engine: one MAC per cycle over N_IN inputs for each of
// N_OUT neurons, with rounding, bias, saturation, optional ReLU and a running argmax.
module fc_layer_engine #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned N_IN   = 256,
  parameter int unsigned N_OUT  = 128,
  parameter int unsigned ACC_W  = 2 * DATA_W + $clog2(N_IN),
  localparam int unsigned IN_AW  = $clog2(N_IN),
  localparam int unsigned W_AW   = $clog2(N_IN * N_OUT),
  localparam int unsigned OUT_AW = $clog2(N_OUT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     relu_en,
  input  logic                     abort,
  output logic [IN_AW-1:0]         in_addr,
  input  logic signed [DATA_W-1:0] in_data,
  output logic [W_AW-1:0]          w_addr,
  input  logic signed [DATA_W-1:0] w_data,
  output logic [OUT_AW-1:0]        b_addr,
  input  logic signed [DATA_W-1:0] b_data,
  output logic                     out_we,
  output logic [OUT_AW-1:0]        out_addr,
  output logic [DATA_W-1:0]        out_data,
  output logic                     busy,
  output logic                     done,
  output logic [OUT_AW-1:0]        max_class,
  output logic signed [DATA_W-1:0] max_val
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam logic [IN_AW-1:0]  LAST_J = IN_AW'(N_IN - 1);
  localparam logic [OUT_AW-1:0] LAST_K = OUT_AW'(N_OUT - 1);
  localparam logic signed [SUM_W-1:0] RND   = SUM_W'(2 ** (FRAC_W - 1));
  localparam logic signed [SUM_W-1:0] Y_MAX = SUM_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [SUM_W-1:0] Y_MIN = -SUM_W'(2 ** (DATA_W - 1));

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_POST, S_DONE} state_e;

  state_e                    state_q, state_d;
  logic                      relu_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic                      abort_c;
  logic signed [PROD_W-1:0]  prod_c;
  logic signed [ACC_W-1:0]   acc_sum_c;
  logic signed [SUM_W-1:0]   rnd_c;
  logic signed [SUM_W-1:0]   ysum_c;
  logic signed [DATA_W-1:0]  sat_c;
  logic signed [DATA_W-1:0]  y_c;

  assign abort_c = abort && (state_q != S_IDLE);

  // Product of the data returned for last cycle's address, and the neuron result path.
  always_comb begin
    prod_c    = PROD_W'(in_data) * PROD_W'(w_data);
    acc_sum_c = acc_q + ACC_W'(prod_c);
    rnd_c     = (SUM_W'(acc_sum_c) + RND) >>> FRAC_W;
    ysum_c    = rnd_c + SUM_W'(b_data);
    if (ysum_c > Y_MAX) begin
      sat_c = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (ysum_c < Y_MIN) begin
      sat_c = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      sat_c = DATA_W'(ysum_c);
    end
    y_c = (relu_q && sat_c[DATA_W-1]) ? '0 : sat_c;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && !abort) state_d = S_MAC;
      S_MAC:   if (in_addr == LAST_J) state_d = S_DRAIN;
      S_DRAIN: state_d = S_POST;
      S_POST:  state_d = (b_addr == LAST_K) ? S_DONE : S_MAC;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_c) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // in_addr doubles as the input index j and b_addr as the neuron index k.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_addr   <= '0;
      w_addr    <= '0;
      b_addr    <= '0;
      out_we    <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      max_class <= '0;
      max_val   <= '0;
      acc_q     <= '0;
      relu_q    <= 1'b0;
    end else begin
      out_we <= 1'b0;
      done   <= 1'b0;
      if (abort_c) begin
        busy <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              relu_q  <= relu_en;
              busy    <= 1'b1;
              in_addr <= '0;
              w_addr  <= '0;
              b_addr  <= '0;
              acc_q   <= '0;
            end
          end
          S_MAC: begin
            if (in_addr != '0) acc_q <= acc_sum_c;
            if (in_addr != LAST_J) begin
              in_addr <= in_addr + IN_AW'(1);
              w_addr  <= w_addr + W_AW'(1);
            end
          end
          S_DRAIN: begin
            // Result is registered here so the write strobe is high during POST.
            acc_q    <= acc_sum_c;
            out_we   <= 1'b1;
            out_addr <= b_addr;
            out_data <= y_c;
            if ((b_addr == '0) || (y_c > max_val)) begin
              max_class <= b_addr;
              max_val   <= y_c;
            end
          end
          S_POST: begin
            if (b_addr == LAST_K) begin
              done <= 1'b1;
              busy <= 1'b0;
            end else begin
              in_addr <= '0;
              w_addr  <= w_addr + W_AW'(1);
              b_addr  <= b_addr + OUT_AW'(1);
              acc_q   <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fc_layer_engine.sv
// Self-checking bench for fc_layer_engine (N_IN=4, N_OUT=3): directed vector table,
// multi-cycle corner sequences, and random layers against an arithmetic reference model.
module tb_fc_layer_engine;

  localparam int DW = 16;
  localparam int FW = 8;
  localparam int NI = 4;
  localparam int NO = 3;
  localparam int IAW = $clog2(NI);
  localparam int WAW = $clog2(NI * NO);
  localparam int BAW = $clog2(NO);

  logic            clk, rst, start, relu_en, abort;
  logic [IAW-1:0]  in_addr;
  logic [WAW-1:0]  w_addr;
  logic [BAW-1:0]  b_addr;
  logic [DW-1:0]   in_data, w_data, b_data;
  logic            out_we, busy, done;
  logic [BAW-1:0]  out_addr, max_class;
  logic [DW-1:0]   out_data, max_val;

  logic [DW-1:0] in_mem [4];
  logic [DW-1:0] w_mem  [16];
  logic [DW-1:0] b_mem  [4];

  int n_checks = 0;
  int n_fail   = 0;

  fc_layer_engine #(.DATA_W(DW), .FRAC_W(FW), .N_IN(NI), .N_OUT(NO)) dut (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en), .abort(abort),
    .in_addr(in_addr), .in_data(in_data), .w_addr(w_addr), .w_data(w_data),
    .b_addr(b_addr), .b_data(b_data), .out_we(out_we), .out_addr(out_addr),
    .out_data(out_data), .busy(busy), .done(done), .max_class(max_class),
    .max_val(max_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memories with one cycle of read latency.
  always @(posedge clk) begin
    in_data <= in_mem[in_addr];
    w_data  <= w_mem[w_addr];
    b_data  <= b_mem[b_addr];
  end

  typedef struct packed {
    logic [NI-1:0][DW-1:0]    in_v;
    logic [NI*NO-1:0][DW-1:0] w_v;
    logic [NO-1:0][DW-1:0]    b_v;
    logic                     relu;
    logic [NO-1:0][DW-1:0]    y;
    logic [1:0]               max_cls;
    logic [DW-1:0]            max_v;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic load_mem(input vec_t v);
    for (int i = 0; i < NI; i++) in_mem[i] = v.in_v[i];
    for (int i = 0; i < NI * NO; i++) w_mem[i] = v.w_v[i];
    for (int i = 0; i < NO; i++) b_mem[i] = v.b_v[i];
  endtask

  // Reference: exact integer dot product, round half up, bias, clamp, ReLU.
  function automatic logic [DW-1:0] ref_neuron(input int k, input logic relu);
    longint acc, y;
    acc = 0;
    for (int j = 0; j < NI; j++)
      acc += longint'($signed(in_mem[j])) * longint'($signed(w_mem[k * NI + j]));
    y = ((acc + (longint'(1) << (FW - 1))) >>> FW) + longint'($signed(b_mem[k]));
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    if (relu && y < 0) y = 0;
    return DW'(y);
  endfunction

  task automatic model_layer(input logic relu, output logic [NO-1:0][DW-1:0] ys,
                             output int cls, output logic [DW-1:0] mx);
    cls = 0;
    for (int k = 0; k < NO; k++) ys[k] = ref_neuron(k, relu);
    mx = ys[0];
    for (int k = 1; k < NO; k++)
      if ($signed(ys[k]) > $signed(mx)) begin
        mx  = ys[k];
        cls = k;
      end
  endtask

  task automatic check_reset();
    check("rst_out_we", out_we, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_in_addr", in_addr, 0);
    check("rst_w_addr", w_addr, 0);
    check("rst_b_addr", b_addr, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_max_class", max_class, 0);
    check("rst_max_val", max_val, 0);
  endtask

  // Runs one layer; cycle n is the cycle beginning n edges after the start edge.
  task automatic run_layer(input logic relu, input int restart_cyc, input int abort_cyc,
                           input logic [NO-1:0][DW-1:0] exp_y, input int exp_cls,
                           input logic [DW-1:0] exp_max);
    int wr_cnt, done_cnt, done_cyc, exp_wr;
    wr_cnt = 0; done_cnt = 0; done_cyc = -1;
    @(negedge clk);
    start = 1'b1; relu_en = relu;
    @(posedge clk);
    #1 start = 1'b0; relu_en = ~relu;
    for (int n = 0; n < 26; n++) begin
      @(negedge clk);
      if (n == 0) check("busy_after_start", busy, 1);
      if (out_we) begin
        if (wr_cnt < NO) begin
          check("wr_cycle", n, wr_cnt * (NI + 2) + NI + 1);
          check("out_addr", out_addr, wr_cnt);
          check("out_data", out_data, exp_y[wr_cnt]);
        end
        wr_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = n;
          check("max_class", max_class, exp_cls);
          check("max_val", max_val, exp_max);
        end
      end
      if (abort_cyc >= 0 && n == abort_cyc + 1) check("busy_after_abort", busy, 0);
      start = (n == restart_cyc);
      abort = (n == abort_cyc);
    end
    start = 1'b0; abort = 1'b0;
    check("busy_idle", busy, 0);
    if (abort_cyc < 0) begin
      check("wr_count", wr_cnt, NO);
      check("done_count", done_cnt, 1);
      check("done_cycle", done_cyc, NO * (NI + 2));
      check("max_class_hold", max_class, exp_cls);
      check("max_val_hold", max_val, exp_max);
    end else begin
      exp_wr = 0;
      for (int k = 0; k < NO; k++) if (k * (NI + 2) + NI + 1 <= abort_cyc) exp_wr++;
      check("wr_count_abort", wr_cnt, exp_wr);
      check("done_count_abort", done_cnt, 0);
      check("max_class_partial", max_class, 0);
      check("max_val_partial", max_val, exp_y[0]);
    end
  endtask

  initial begin
    logic [NO-1:0][DW-1:0] ys;
    int                    cls;
    logic [DW-1:0]         mx;
    logic                  rl;

    for (int i = 0; i < 7; i++) vecs[i] = '0;
    vecs[0].in_v = {NI{16'h0100}}; vecs[0].w_v = {(NI*NO){16'h0080}};
    vecs[0].y = {NO{16'h0200}}; vecs[0].max_v = 16'h0200;
    vecs[1].in_v = {NI{16'h7FFF}}; vecs[1].w_v = {(NI*NO){16'h7FFF}};
    vecs[1].y = {NO{16'h7FFF}}; vecs[1].max_v = 16'h7FFF;
    vecs[2].in_v = {NI{16'h7FFF}}; vecs[2].w_v = {(NI*NO){16'h8001}};
    vecs[2].y = {NO{16'h8000}}; vecs[2].max_v = 16'h8000;
    vecs[3] = vecs[2]; vecs[3].relu = 1'b1;
    vecs[3].y = '0; vecs[3].max_v = 16'h0000;
    vecs[4].in_v[0] = 16'h0080; vecs[4].w_v[0] = 16'h0001; vecs[4].w_v[4] = 16'hFFFF;
    vecs[4].y[0] = 16'h0001; vecs[4].max_v = 16'h0001;
    vecs[5].in_v = {NI{16'h0100}};
    vecs[5].b_v[0] = 16'h0003; vecs[5].b_v[1] = 16'h0005; vecs[5].b_v[2] = 16'h0005;
    vecs[5].y = vecs[5].b_v; vecs[5].max_cls = 2'd1; vecs[5].max_v = 16'h0005;
    vecs[6].in_v[0] = 16'h0081; vecs[6].w_v[0] = 16'hFFFF; vecs[6].w_v[4] = 16'h0003;
    vecs[6].w_v[8] = 16'hFFFD; vecs[6].b_v[1] = 16'h0010;
    vecs[6].y[0] = 16'hFFFF; vecs[6].y[1] = 16'h0012; vecs[6].y[2] = 16'hFFFE;
    vecs[6].max_cls = 2'd1; vecs[6].max_v = 16'h0012;

    for (int i = 0; i < 16; i++) w_mem[i] = '0;
    for (int i = 0; i < 4; i++) begin in_mem[i] = '0; b_mem[i] = '0; end
    rst = 1'b1; start = 1'b0; relu_en = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    check_reset();
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      load_mem(vecs[i]);
      run_layer(vecs[i].relu, -1, -1, vecs[i].y, int'(vecs[i].max_cls), vecs[i].max_v);
    end

    // start while busy is ignored
    load_mem(vecs[0]);
    run_layer(1'b0, 3, -1, vecs[0].y, 0, vecs[0].max_v);

    // abort during neuron 1
    load_mem(vecs[5]);
    run_layer(1'b0, -1, 7, vecs[5].y, 0, vecs[5].max_v);

    // reset mid-run, then a clean run
    @(negedge clk);
    start = 1'b1; relu_en = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1 check_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_after_rst_busy", busy, 0);
      check("idle_after_rst_we", out_we, 0);
    end
    run_layer(1'b0, -1, -1, vecs[5].y, 1, vecs[5].max_v);

    for (int r = 0; r < 20; r++) begin
      rl = 1'($urandom_range(0, 1));
      for (int i = 0; i < NI; i++)
        in_mem[i] = (r % 2 == 1) ? 16'($urandom) : 16'($urandom_range(0, 1023) - 512);
      for (int i = 0; i < NI * NO; i++)
        w_mem[i] = (r % 3 == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023) - 512);
      for (int i = 0; i < NO; i++) b_mem[i] = 16'($urandom_range(0, 255) - 128);
      model_layer(rl, ys, cls, mx);
      run_layer(rl, -1, -1, ys, cls, mx);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
